// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex multi-word UART with ready/valid streams and loopback
//
// Purpose:
//   Serialises W_OUT-bit transfers as NUM_WORDS UART characters (word 0 first,
//   each LSB first) and deserialises incoming characters back into W_OUT-bit
//   transfers. TX and RX run independent FSMs. A runtime loopback feeds the
//   internal tx line straight into the receiver.
//
// Optional feature macro: UART_PARITY_EN
//   defined   : a parity bit follows the data bits on TX and is checked on RX
//               (PARITY_ODD selects odd/even)
//   undefined : frame is start + data + stop, parity_err is tied low
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   loopback     1: receiver listens to internal tx, 0: to the rx pin
//   rx, tx       serial input (asynchronous), serial output (idle high)
//   s_valid/s_ready/s_data      TX transfer stream, s_data word 0 sent first
//   m_valid/m_ready/m_data      RX transfer stream, first word in m_data[BPW-1:0]
//   parity_err, frame_err       status of the transfer held on m_data
//   overrun      one-cycle pulse when a completed transfer is dropped

module uart_transceiver #(
   parameter int  CLOCKS_PER_PULSE = 5208,
   parameter int  BITS_PER_WORD    = 8,
   parameter int  W_OUT            = 16,
   parameter int  PARITY_ODD       = 0,
   localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
   input  logic                                          clk,
   input  logic                                          rstn,
   input  logic                                          loopback,
   input  logic                                          rx,
   output logic                                          tx,
   input  logic                                          s_valid,
   output logic                                          s_ready,
   input  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]       s_data,
   output logic                                          m_valid,
   input  logic                                          m_ready,
   output logic [W_OUT-1:0]                              m_data,
   output logic                                          parity_err,
   output logic                                          frame_err,
   output logic                                          overrun
);

   localparam int TW     = $clog2(CLOCKS_PER_PULSE);
   localparam int BIT_W  = $clog2(BITS_PER_WORD + 1);
   localparam int WORD_W = $clog2(NUM_WORDS + 1);

   localparam logic [TW-1:0]     BIT_END   = TW'(CLOCKS_PER_PULSE - 1);
   localparam logic [TW-1:0]     HALF_END  = TW'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BITS_PER_WORD - 1);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

   if (CLOCKS_PER_PULSE < 4) begin : g_chk_cpp
      $error("uart_transceiver: CLOCKS_PER_PULSE must be >= 4");
   end
   if ((W_OUT % BITS_PER_WORD) != 0 || W_OUT < BITS_PER_WORD) begin : g_chk_width
      $error("uart_transceiver: W_OUT must be a non-zero multiple of BITS_PER_WORD");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_parity
      $error("uart_transceiver: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // ---------------------------------------------------------------- TX
   state_t              tx_state, tx_state_next;
   logic [TW-1:0]       tx_timer;
   logic [BIT_W-1:0]    tx_bit;
   logic [WORD_W-1:0]   tx_word;
   logic [W_OUT-1:0]    tx_shift;    // whole payload shifts out LSB first, word 0 leads
   logic                tx_tick;
   logic                tx_line;
`ifdef UART_PARITY_EN
   logic                tx_par;      // running XOR of the current word's data bits
`endif

   assign tx_tick = (tx_timer == BIT_END);
   assign s_ready = (tx_state == S_IDLE);
   assign tx      = tx_line;

   always_ff @(posedge clk) begin
      if (!rstn) tx_state <= S_IDLE;
      else       tx_state <= tx_state_next;
   end

   always_comb begin
      tx_state_next = tx_state;
      tx_line       = 1'b1;
      case (tx_state)
         S_IDLE: begin
            if (s_valid) tx_state_next = S_START;
         end
         S_START: begin
            tx_line = 1'b0;
            if (tx_tick) tx_state_next = S_DATA;
         end
         S_DATA: begin
            tx_line = tx_shift[0];
            if (tx_tick && tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
               tx_state_next = S_PARITY;
`else
               tx_state_next = S_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            tx_line = tx_par ^ PAR_ODD;
            if (tx_tick) tx_state_next = S_STOP;
         end
`endif
         S_STOP: begin
            if (tx_tick) tx_state_next = (tx_word == LAST_WORD) ? S_IDLE : S_START;
         end
         default: tx_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_timer <= '0;
         tx_bit   <= '0;
         tx_word  <= '0;
         tx_shift <= '0;
`ifdef UART_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         if (tx_state == S_IDLE || tx_tick) tx_timer <= '0;
         else                               tx_timer <= tx_timer + 1'b1;

         case (tx_state)
            S_IDLE: begin
               if (s_valid) begin
                  tx_shift <= s_data;
                  tx_word  <= '0;
                  tx_bit   <= '0;
`ifdef UART_PARITY_EN
                  tx_par   <= 1'b0;
`endif
               end
            end
            S_DATA: begin
               if (tx_tick) begin
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= (tx_bit == LAST_BIT) ? '0 : tx_bit + 1'b1;
`ifdef UART_PARITY_EN
                  tx_par   <= tx_par ^ tx_shift[0];
`endif
               end
            end
            S_STOP: begin
               if (tx_tick) begin
                  tx_word <= tx_word + 1'b1;
`ifdef UART_PARITY_EN
                  tx_par  <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- RX
   logic [1:0]          rx_sync;
   logic                rx_line, rx_prev;
   state_t              rx_state, rx_state_next;
   logic [TW-1:0]       rx_timer;
   logic [BIT_W-1:0]    rx_bit;
   logic [WORD_W-1:0]   rx_word;
   logic [W_OUT-1:0]    rx_buf;      // shifts in at the MSB so the first bit lands at bit 0
   logic                rx_ferr_acc;
   logic                rx_step;
   logic                rx_xfer_done;
`ifdef UART_PARITY_EN
   logic                rx_par;
   logic                rx_perr_acc;
   logic                m_perr;
`endif

   // Loopback taps the internal line directly; it is already in this clock domain.
   assign rx_line = loopback ? tx_line : rx_sync[1];

   // START waits half a bit to land mid-bit; every later sample is a full bit apart.
   assign rx_step      = (rx_state == S_START) ? (rx_timer == HALF_END) : (rx_timer == BIT_END);
   assign rx_xfer_done = (rx_state == S_STOP) && rx_step && (rx_word == LAST_WORD);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
      end else begin
         rx_sync  <= {rx_sync[0], rx};
         rx_prev  <= rx_line;
         rx_state <= rx_state_next;
      end
   end

   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         S_IDLE: begin
            if (rx_prev && !rx_line) rx_state_next = S_START;
         end
         S_START: begin
            if (rx_step) rx_state_next = rx_line ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (rx_step && rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
               rx_state_next = S_PARITY;
`else
               rx_state_next = S_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (rx_step) rx_state_next = S_STOP;
         end
`endif
         S_STOP: begin
            if (rx_step) rx_state_next = S_IDLE;
         end
         default: rx_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_timer    <= '0;
         rx_bit      <= '0;
         rx_word     <= '0;
         rx_buf      <= '0;
         rx_ferr_acc <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par      <= 1'b0;
         rx_perr_acc <= 1'b0;
`endif
      end else begin
         if (rx_state == S_IDLE || rx_step) rx_timer <= '0;
         else                               rx_timer <= rx_timer + 1'b1;

         case (rx_state)
            S_START: begin
               if (rx_step && !rx_line) begin
`ifdef UART_PARITY_EN
                  rx_par <= 1'b0;
                  if (rx_word == '0) rx_perr_acc <= 1'b0;
`endif
                  if (rx_word == '0) rx_ferr_acc <= 1'b0;
               end
            end
            S_DATA: begin
               if (rx_step) begin
                  rx_buf <= {rx_line, rx_buf[W_OUT-1:1]};
                  rx_bit <= (rx_bit == LAST_BIT) ? '0 : rx_bit + 1'b1;
`ifdef UART_PARITY_EN
                  rx_par <= rx_par ^ rx_line;
`endif
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (rx_step) rx_perr_acc <= rx_perr_acc | (rx_par ^ rx_line ^ PAR_ODD);
            end
`endif
            S_STOP: begin
               if (rx_step) begin
                  rx_ferr_acc <= rx_ferr_acc | ~rx_line;
                  rx_word     <= (rx_word == LAST_WORD) ? '0 : rx_word + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // A completion coinciding with the consumer's acceptance reloads instead of dropping.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         m_valid   <= 1'b0;
         m_data    <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_PARITY_EN
         m_perr    <= 1'b0;
`endif
      end else begin
         overrun <= 1'b0;
         if (rx_xfer_done) begin
            if (!m_valid || m_ready) begin
               m_valid   <= 1'b1;
               m_data    <= rx_buf;
               frame_err <= rx_ferr_acc | ~rx_line;
`ifdef UART_PARITY_EN
               m_perr    <= rx_perr_acc;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

`ifdef UART_PARITY_EN
   assign parity_err = m_perr;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - self-checking bench for uart_transceiver
`timescale 1ns/1ps
module tb_uart_transceiver;

   localparam int CPP = 4;
   localparam int BPW = 8;
   localparam int W   = 16;
   localparam int NW  = W / BPW;

   logic          clk = 1'b0;
   logic          rstn;
   logic          loopback;
   logic          rx;
   logic          tx;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic          m_valid;
   logic          m_ready;
   logic [W-1:0]  m_data;
   logic          parity_err;
   logic          frame_err;
   logic          overrun;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_transceiver #(
      .CLOCKS_PER_PULSE (CPP),
      .BITS_PER_WORD    (BPW),
      .W_OUT            (W),
      .PARITY_ODD       (0)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .loopback   (loopback),
      .rx         (rx),
      .tx         (tx),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         perr;
      logic         ferr;
   } rx_rec_t;

   typedef struct {
      logic         use_pin;
      logic [W-1:0] payload;
      logic [1:0]   bad_stop;
      logic [1:0]   bad_par;
      logic [W-1:0] exp_data;
      logic         exp_perr;
      logic         exp_ferr;
   } vec_t;

   rx_rec_t rx_q[$];
   int      ovr_cnt = 0;

   always @(negedge clk) begin
      if (rstn && m_valid && m_ready) rx_q.push_back('{m_data, parity_err, frame_err});
      if (rstn && overrun) ovr_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Serial picture of one transfer: per word start 0, data LSB first, [parity], stop 1.
   function automatic void build_frame(input logic [W-1:0] p, input logic [1:0] bad_stop,
                                       input logic [1:0] bad_par,
                                       output logic [63:0] bits, output int nb);
      logic [BPW-1:0] word;
      bits = '0;
      nb   = 0;
      for (int w = 0; w < NW; w++) begin
         word = p[w*BPW +: BPW];
         bits[nb] = 1'b0;
         nb++;
         for (int b = 0; b < BPW; b++) begin
            bits[nb] = word[b];
            nb++;
         end
`ifdef UART_PARITY_EN
         bits[nb] = (^word) ^ bad_par[w];
         nb++;
`endif
         bits[nb] = ~bad_stop[w];
         nb++;
      end
   endfunction

   function automatic logic exp_perr(input logic [1:0] bad_par);
`ifdef UART_PARITY_EN
      return |bad_par;
`else
      return 1'b0;
`endif
   endfunction

   task automatic send_tx(input logic [W-1:0] payload, input string tag);
      logic [63:0] exp_bits;
      logic [63:0] got_bits;
      int          nb;
      int          budget;
      build_frame(payload, 2'b00, 2'b00, exp_bits, nb);
      @(negedge clk);
      budget = 0;
      while (!s_ready && budget < 400) begin
         @(negedge clk);
         budget++;
      end
      check({tag, " s_ready before send"}, 64'(s_ready), 64'd1);
      s_data  = payload;
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      got_bits = '0;
      @(negedge clk);
      @(negedge clk);
      got_bits[0] = tx;
      for (int j = 1; j < nb; j++) begin
         repeat (CPP) @(negedge clk);
         got_bits[j] = tx;
      end
      check({tag, " tx bitstream"}, got_bits, exp_bits);
      repeat (CPP - 2) @(negedge clk);
      check({tag, " s_ready low in last stop"}, 64'(s_ready), 64'd0);
      @(negedge clk);
      check({tag, " s_ready after last stop"}, 64'(s_ready), 64'd1);
   endtask

   task automatic drive_rx(input logic [W-1:0] payload, input logic [1:0] bad_stop,
                           input logic [1:0] bad_par);
      logic [63:0] bits;
      int          nb;
      build_frame(payload, bad_stop, bad_par, bits, nb);
      @(negedge clk);
      for (int j = 0; j < nb; j++) begin
         rx = bits[j];
         repeat (CPP) @(negedge clk);
      end
      rx = 1'b1;
      repeat (3 * CPP) @(negedge clk);
   endtask

   task automatic expect_rx(input string tag, input logic [W-1:0] d, input logic pe,
                            input logic fe);
      rx_rec_t rec;
      int      budget;
      budget = 0;
      while (rx_q.size() == 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check({tag, " transfers received"}, 64'(rx_q.size()), 64'd1);
      if (rx_q.size() > 0) begin
         rec = rx_q.pop_front();
         check({tag, " m_data"}, 64'(rec.data), 64'(d));
         check({tag, " parity_err"}, 64'(rec.perr), 64'(pe));
         check({tag, " frame_err"}, 64'(rec.ferr), 64'(fe));
      end
   endtask

   initial begin
      vec_t         vecs[$];
      logic [W-1:0] p;
      logic [1:0]   bs;
      logic [1:0]   bp;
      int           ovr_base;

      vecs.push_back('{use_pin: 1'b0, payload: 16'hA53C, bad_stop: 2'b00, bad_par: 2'b00,
                       exp_data: 16'hA53C, exp_perr: 1'b0, exp_ferr: 1'b0});
      vecs.push_back('{use_pin: 1'b0, payload: 16'h0000, bad_stop: 2'b00, bad_par: 2'b00,
                       exp_data: 16'h0000, exp_perr: 1'b0, exp_ferr: 1'b0});
      vecs.push_back('{use_pin: 1'b0, payload: 16'hFFFF, bad_stop: 2'b00, bad_par: 2'b00,
                       exp_data: 16'hFFFF, exp_perr: 1'b0, exp_ferr: 1'b0});
      vecs.push_back('{use_pin: 1'b1, payload: 16'h1234, bad_stop: 2'b00, bad_par: 2'b00,
                       exp_data: 16'h1234, exp_perr: 1'b0, exp_ferr: 1'b0});
      vecs.push_back('{use_pin: 1'b1, payload: 16'h5AC3, bad_stop: 2'b10, bad_par: 2'b00,
                       exp_data: 16'h5AC3, exp_perr: 1'b0, exp_ferr: 1'b1});
`ifdef UART_PARITY_EN
      vecs.push_back('{use_pin: 1'b1, payload: 16'h0001, bad_stop: 2'b00, bad_par: 2'b01,
                       exp_data: 16'h0001, exp_perr: 1'b1, exp_ferr: 1'b0});
`endif

      rstn     = 1'b0;
      loopback = 1'b0;
      rx       = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      m_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      check("reset tx", 64'(tx), 64'd1);
      check("reset s_ready", 64'(s_ready), 64'd1);
      check("reset m_valid", 64'(m_valid), 64'd0);
      check("reset m_data", 64'(m_data), 64'd0);
      check("reset parity_err", 64'(parity_err), 64'd0);
      check("reset frame_err", 64'(frame_err), 64'd0);
      check("reset overrun", 64'(overrun), 64'd0);

      foreach (vecs[i]) begin
         loopback = ~vecs[i].use_pin;
         if (vecs[i].use_pin) drive_rx(vecs[i].payload, vecs[i].bad_stop, vecs[i].bad_par);
         else                 send_tx(vecs[i].payload, $sformatf("vec%0d", i));
         expect_rx($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      end

      loopback = 1'b1;
      for (int i = 0; i < 6; i++) begin
         p = W'($urandom);
         send_tx(p, $sformatf("rand_lb%0d", i));
         expect_rx($sformatf("rand_lb%0d", i), p, 1'b0, 1'b0);
      end

      loopback = 1'b0;
      for (int i = 0; i < 6; i++) begin
         p  = W'($urandom);
         bs = {1'($urandom_range(0, 1)), 1'b0};
         bp = 2'($urandom);
         drive_rx(p, bs, bp);
         expect_rx($sformatf("rand_pin%0d", i), p, exp_perr(bp), |bs);
      end

      // Held transfer with consumer stalled: second completion must be dropped.
      @(posedge clk);
      #1 m_ready = 1'b0;
      loopback = 1'b1;
      ovr_base = ovr_cnt;
      send_tx(16'h1111, "ovr_first");
      send_tx(16'h2222, "ovr_second");
      repeat (2 * CPP) @(negedge clk);
      check("ovr m_valid held", 64'(m_valid), 64'd1);
      check("ovr m_data held", 64'(m_data), 64'h1111);
      check("ovr pulse count", 64'(ovr_cnt - ovr_base), 64'd1);
      @(posedge clk);
      #1 m_ready = 1'b1;
      expect_rx("ovr drain", 16'h1111, 1'b0, 1'b0);
      @(negedge clk);
      check("ovr m_valid cleared", 64'(m_valid), 64'd0);

      // One-cycle low on rx must not start a character.
      loopback = 1'b0;
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (6 * CPP) @(negedge clk);
      check("glitch m_valid", 64'(m_valid), 64'd0);
      check("glitch nothing received", 64'(rx_q.size()), 64'd0);
      drive_rx(16'hBEEF, 2'b00, 2'b00);
      expect_rx("after glitch", 16'hBEEF, 1'b0, 1'b0);

      // Reset pulse in the middle of a TX data phase.
      loopback = 1'b1;
      @(negedge clk);
      s_data  = 16'h0000;
      s_valid = 1'b1;
      @(posedge clk);
      #1 s_valid = 1'b0;
      repeat (CPP + 3) @(negedge clk);
      check("mid data tx low", 64'(tx), 64'd0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check("post reset tx", 64'(tx), 64'd1);
      check("post reset s_ready", 64'(s_ready), 64'd1);
      check("post reset m_valid", 64'(m_valid), 64'd0);
      repeat (6 * CPP) @(negedge clk);
      check("post reset partial dropped", 64'(rx_q.size()), 64'd0);
      send_tx(16'h6C93, "after_reset");
      expect_rx("after_reset", 16'h6C93, 1'b0, 1'b0);

      repeat (4 * CPP) @(negedge clk);
      check("total overrun pulses", 64'(ovr_cnt - ovr_base), 64'd1);
      check("stray transfers", 64'(rx_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
